// File: rtl/rx_sample_packer.sv
// RX sample packer: captures up to two I/Q channel pairs on each decimated strobe and
// serializes them as WIDTH-bit RX FIFO writes. Optional 8-bit packing mode under `RX_PACK8_EN`.
//
// state  | meaning
// IDLE   | waiting for strobe & enable; fifo_we low
// EMIT   | draining the held sample set, one word per non-full cycle
module rx_sample_packer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             strobe,
    input  logic             nchan,
`ifdef RX_PACK8_EN
    input  logic             mode8,
`endif
    input  logic [WIDTH-1:0] ch0_i,
    input  logic [WIDTH-1:0] ch0_q,
    input  logic [WIDTH-1:0] ch1_i,
    input  logic [WIDTH-1:0] ch1_q,
    input  logic             fifo_full,
    output logic [WIDTH-1:0] fifo_wdata,
    output logic             fifo_we,
    output logic             busy,
    output logic             overrun,
    input  logic             clear_overrun,
    output logic [CNT_W-1:0] sample_count
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]       state;
    logic [2:0]       idx;
    logic [2:0]       nwords;
    logic [WIDTH-1:0] hold [4];
    logic [WIDTH-1:0] cap_word [4];
    logic [2:0]       cap_nwords;

    always_comb begin
        cap_word[0] = ch0_i;
        cap_word[1] = ch0_q;
        cap_word[2] = ch1_i;
        cap_word[3] = ch1_q;
        cap_nwords  = nchan ? 3'd4 : 3'd2;
`ifdef RX_PACK8_EN
        // 8-bit mode keeps only the upper half of I and Q, one word per channel
        if (mode8) begin
            cap_word[0] = {ch0_i[WIDTH-1 -: WIDTH/2], ch0_q[WIDTH-1 -: WIDTH/2]};
            cap_word[1] = {ch1_i[WIDTH-1 -: WIDTH/2], ch1_q[WIDTH-1 -: WIDTH/2]};
            cap_nwords  = nchan ? 3'd2 : 3'd1;
        end
`endif
    end

    assign busy = (state == S_EMIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            idx          <= '0;
            nwords       <= '0;
            fifo_we      <= 1'b0;
            fifo_wdata   <= '0;
            overrun      <= 1'b0;
            sample_count <= '0;
            for (int k = 0; k < 4; k++) hold[k] <= '0;
        end else begin
            fifo_we <= 1'b0;
            // a same-cycle overrun below overrides this clear
            if (clear_overrun) overrun <= 1'b0;

            if (!enable) begin
                state        <= S_IDLE;
                sample_count <= '0;
            end else if (state == S_IDLE) begin
                if (strobe) begin
                    hold         <= cap_word;
                    nwords       <= cap_nwords;
                    sample_count <= sample_count + 1'b1;
                    state        <= S_EMIT;
                    // first word goes out straight from the inputs to hit N+1 latency
                    if (!fifo_full) begin
                        fifo_we    <= 1'b1;
                        fifo_wdata <= cap_word[0];
                        idx        <= 3'd1;
                    end else begin
                        idx <= 3'd0;
                    end
                end
            end else begin
                if (strobe) overrun <= 1'b1;
                // EMIT persists through the last-word cycle so a strobe there is an overrun
                if (idx == nwords) begin
                    state <= S_IDLE;
                end else if (!fifo_full) begin
                    fifo_we    <= 1'b1;
                    fifo_wdata <= hold[idx[1:0]];
                    idx        <= idx + 3'd1;
                end
            end
        end
    end

endmodule
